bpsk_demodulator: RTL and testbench



---
 rtl/bpsk_pkg.sv | 19 +
 rtl/bpsk_correlator.sv | 68 ++++++
 rtl/bpsk_demodulator.sv | 91 +++++++++
 tb/tb_bpsk_demodulator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared BPSK constants: default widths, the quarter-wave-symmetric sine table
// and the sample type used by both the transmit wave table and the receiver.
package bpsk_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int SINE_RESOLUTION = 8;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  // Positive half period of the carrier; the negative half is its negation.
  localparam sample_t SINE_TABLE [0:SINE_RESOLUTION-1] = '{
    8'sd0, 8'sd48, 8'sd89, 8'sd117, 8'sd127, 8'sd117, 8'sd89, 8'sd48
  };

  function automatic int sym_len(input int resolution, input int cycles);
    return 2 * resolution * cycles;
  endfunction

endpackage

// File: rtl/bpsk_correlator.sv
// Multiplies each accepted sample by the local sine reference and integrates
// over one symbol; o_sum is the running integral including the current sample.
module bpsk_correlator #(
  parameter  int DATA_WIDTH        = bpsk_pkg::DATA_WIDTH,
  parameter  int SINE_RESOLUTION   = bpsk_pkg::SINE_RESOLUTION,
  parameter  int CYCLES_PER_SYMBOL = 1,
  localparam int SYM_LEN           = 2 * SINE_RESOLUTION * CYCLES_PER_SYMBOL,
  localparam int ACC_WIDTH         = 2 * DATA_WIDTH + $clog2(SYM_LEN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_accept,
  input  logic                         i_restart,
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  output logic signed [ACC_WIDTH-1:0]  o_sum,
  output logic                         o_last
);

  import bpsk_pkg::*;

  localparam int IDX_W = $clog2(SYM_LEN);
  localparam int PH_W  = $clog2(2 * SINE_RESOLUTION);
  localparam int TAB_W = $clog2(SINE_RESOLUTION);
  localparam int PW    = 2 * DATA_WIDTH;

  logic        [IDX_W-1:0]      r_idx;
  logic signed [ACC_WIDTH-1:0]  r_acc;

  logic        [IDX_W-1:0]      w_idx;
  logic        [PH_W-1:0]       w_phase;
  logic                         w_neg_half;
  logic        [TAB_W-1:0]      w_tab_idx;
  logic signed [DATA_WIDTH-1:0] w_tab_val;
  logic signed [DATA_WIDTH-1:0] w_ref;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_base;

  // A symbol strobe makes the current sample index 0 of a fresh integral.
  assign w_idx  = i_restart ? '0 : r_idx;
  assign w_base = i_restart ? '0 : r_acc;

  assign w_phase    = PH_W'(32'(w_idx) % (2 * SINE_RESOLUTION));
  assign w_neg_half = (w_phase >= PH_W'(SINE_RESOLUTION));
  assign w_tab_idx  = w_neg_half ? TAB_W'(w_phase - PH_W'(SINE_RESOLUTION))
                                 : TAB_W'(w_phase);
  assign w_tab_val  = DATA_WIDTH'(SINE_TABLE[w_tab_idx]);
  assign w_ref      = w_neg_half ? -w_tab_val : w_tab_val;

  assign w_prod = PW'(i_sample) * PW'(w_ref);
  assign o_sum  = w_base + ACC_WIDTH'(w_prod);
  assign o_last = i_accept && (w_idx == IDX_W'(SYM_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_restart || i_accept) begin
      if (!i_accept || o_last) begin
        r_idx <= '0;
        r_acc <= '0;
      end else begin
        r_idx <= w_idx + 1'b1;
        r_acc <= o_sum;
      end
    end
  end

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK receiver: waits for a symbol strobe, then slices the sign of
// each symbol's correlation into a bit presented on a valid/ready output.
module bpsk_demodulator #(
  parameter  int DATA_WIDTH        = bpsk_pkg::DATA_WIDTH,
  parameter  int SINE_RESOLUTION   = bpsk_pkg::SINE_RESOLUTION,
  parameter  int CYCLES_PER_SYMBOL = 1,
  localparam int SYM_LEN           = 2 * SINE_RESOLUTION * CYCLES_PER_SYMBOL,
  localparam int ACC_WIDTH         = 2 * DATA_WIDTH + $clog2(SYM_LEN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic                         sym_sync,
  output logic                         bit_out,
  output logic                         bit_valid,
  input  logic                         bit_ready,
  output logic                         overrun,
  output logic                         locked,
  output logic signed [ACC_WIDTH-1:0]  corr
);

  import bpsk_pkg::*;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  logic [0:0]                  r_state;
  logic                        r_bit_out;
  logic                        r_bit_valid;
  logic                        r_overrun;
  logic signed [ACC_WIDTH-1:0] r_corr;

  logic                        w_accept;
  logic                        w_last;
  logic                        w_positive;
  logic signed [ACC_WIDTH-1:0] w_sum;

  assign w_accept   = sample_valid && ((r_state == ST_TRACK) || sym_sync);
  assign w_positive = !w_sum[ACC_WIDTH-1] && (w_sum != '0);

  bpsk_correlator #(
    .DATA_WIDTH        (DATA_WIDTH),
    .SINE_RESOLUTION   (SINE_RESOLUTION),
    .CYCLES_PER_SYMBOL (CYCLES_PER_SYMBOL)
  ) u_correlator (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_accept  (w_accept),
    .i_restart (sym_sync),
    .i_sample  (sample),
    .o_sum     (w_sum),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (sym_sync) begin
      r_state <= ST_TRACK;
    end
  end

  // A fresh decision always wins; it only counts as an overrun if the
  // previous bit is still pending and not being taken this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_corr      <= '0;
    end else if (w_last) begin
      r_bit_out   <= w_positive;
      r_corr      <= w_sum;
      r_bit_valid <= 1'b1;
      r_overrun   <= r_bit_valid && !bit_ready;
    end else begin
      r_overrun <= 1'b0;
      if (r_bit_valid && bit_ready) begin
        r_bit_valid <= 1'b0;
      end
    end
  end

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign overrun   = r_overrun;
  assign locked    = (r_state == ST_TRACK);
  assign corr      = r_corr;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Directed bench for bpsk_demodulator: sine-table symbols with hand-computed
// correlations (sum of squares of the table over one period = 127914).
module tb_bpsk_demodulator;

  localparam int ACC_W     = 20;
  localparam int FULL_CORR = 127914;
  localparam int SINE_TAB [8] = '{0, 48, 89, 117, 127, 117, 89, 48};

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    sample_valid;
  logic signed [7:0]       sample;
  logic                    sym_sync;
  logic                    bit_out;
  logic                    bit_valid;
  logic                    bit_ready;
  logic                    overrun;
  logic                    locked;
  logic signed [ACC_W-1:0] corr;

  int   errors = 0;
  int   checks = 0;
  int   rises = 0;
  int   overruns = 0;
  int   base = 0;
  logic prevValid = 1'b0;

  always #5 clk = ~clk;

  bpsk_demodulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sym_sync     (sym_sync),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .overrun      (overrun),
    .locked       (locked),
    .corr         (corr)
  );

  // Counts decisions (rising bit_valid) and overrun pulses between checks.
  always @(negedge clk) begin
    if (bit_valid && !prevValid) rises++;
    if (overrun) overruns++;
    prevValid = bit_valid;
  end

  function automatic int refAt(input int i);
    return (i < 8) ? SINE_TAB[i] : -SINE_TAB[i-8];
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int value, input logic valid, input logic sync);
    @(negedge clk);
    sample       = 8'(value);
    sample_valid = valid;
    sym_sync     = sync;
    @(posedge clk);
    #1;
  endtask

  task automatic sendSymbol(input int sign, input logic syncFirst);
    for (int i = 0; i < 16; i++) applyStimulus(sign * refAt(i), 1'b1, syncFirst && (i == 0));
  endtask

  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sym_sync = 1'b0; sample = '0; bit_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid",   bit_valid, 0);
    checkOutput("rstBit",     bit_out,   0);
    checkOutput("rstOverrun", overrun,   0);
    checkOutput("rstLocked",  locked,    0);
    checkOutput("rstCorr",    corr,      0);
    @(negedge clk) rst_n = 1'b1;

    base = rises;
    for (int i = 0; i < 32; i++) applyStimulus(refAt(i % 16), 1'b1, 1'b0);
    checkOutput("idleNoDecision", rises - base, 0);
    checkOutput("idleValid",      bit_valid,    0);
    checkOutput("idleLocked",     locked,       0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(refAt(i), 1'b1, i == 0);
      if (i == 0)  checkOutput("syncLocked", locked, 1);
      if (i == 14) checkOutput("posEarly", bit_valid, 0);
    end
    checkOutput("posValid", bit_valid, 1);
    checkOutput("posBit",   bit_out,   1);
    checkOutput("posCorr",  corr,      FULL_CORR);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("posHeld", bit_valid, 1);
    bit_ready = 1'b1;
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("posDrop", bit_valid, 0);

    sendSymbol(-1, 1'b0);
    checkOutput("negValid",   bit_valid, 1);
    checkOutput("negBit",     bit_out,   0);
    checkOutput("negCorr",    corr,      -FULL_CORR);
    checkOutput("negOverrun", overrun,   0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("negDrop", bit_valid, 0);

    bit_ready = 1'b0;
    base = overruns;
    sendSymbol(1, 1'b0);
    checkOutput("ovFirstBit",     bit_out, 1);
    checkOutput("ovFirstOverrun", overrun, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(-refAt(i), 1'b1, 1'b0);
      if (i == 7) begin
        checkOutput("stableBit",  bit_out, 1);
        checkOutput("stableCorr", corr,    FULL_CORR);
      end
    end
    checkOutput("ovPulse", overrun,   1);
    checkOutput("ovBit",   bit_out,   0);
    checkOutput("ovCorr",  corr,      -FULL_CORR);
    checkOutput("ovValid", bit_valid, 1);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("ovOneCycle", overrun,         0);
    checkOutput("ovCount",    overruns - base, 1);

    for (int i = 0; i < 16; i++) begin
      if (i == 15) bit_ready = 1'b1;
      applyStimulus(refAt(i), 1'b1, 1'b0);
    end
    checkOutput("handoffOverrun", overrun,   0);
    checkOutput("handoffValid",   bit_valid, 1);
    checkOutput("handoffBit",     bit_out,   1);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("handoffDrop",  bit_valid,       0);
    checkOutput("handoffCount", overruns - base, 1);

    sendSymbol(0, 1'b0);
    checkOutput("zeroValid", bit_valid, 1);
    checkOutput("zeroCorr",  corr,      0);
    checkOutput("zeroBit",   bit_out,   0);
    applyStimulus(0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1'b1, 1'b0);
      if (i == 15) begin
        checkOutput("gapValid", bit_valid, 1);
        checkOutput("gapCorr",  corr,      0);
        checkOutput("gapBit",   bit_out,   0);
      end
      applyStimulus(0, 1'b0, 1'b0);
      if (i == 14) checkOutput("gapEarly", bit_valid, 0);
    end

    base = rises;
    for (int i = 0; i < 7; i++) applyStimulus(-refAt(i), 1'b1, 1'b0);
    sendSymbol(1, 1'b1);
    checkOutput("resyncValid", bit_valid, 1);
    checkOutput("resyncBit",   bit_out,   1);
    checkOutput("resyncCorr",  corr,      FULL_CORR);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("resyncSingle", rises - base, 1);

    base = rises;
    for (int i = 0; i < 15; i++) applyStimulus(-refAt(i), 1'b1, 1'b0);
    sendSymbol(1, 1'b1);
    checkOutput("endSyncBit",  bit_out, 1);
    checkOutput("endSyncCorr", corr,    FULL_CORR);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("endSyncSingle", rises - base, 1);

    bit_ready = 1'b0;
    sendSymbol(1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(refAt(i), 1'b1, 1'b0);
    checkOutput("preRstValid", bit_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncValid",   bit_valid, 0);
    checkOutput("asyncBit",     bit_out,   0);
    checkOutput("asyncCorr",    corr,      0);
    checkOutput("asyncLocked",  locked,    0);
    checkOutput("asyncOverrun", overrun,   0);
    @(negedge clk) rst_n = 1'b1;
    base = rises;
    sendSymbol(1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0);
    checkOutput("postRstNoDecision", rises - base, 0);
    checkOutput("postRstLocked",     locked,       0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
